// File: rtl/grayscale_wr_engine.sv
// grayscale_wr_engine: drains 512-bit result lines from the grayscale output
// FIFO into consecutive cache-line write requests, honouring the write
// channel's almost-full back-pressure, and reports completion once every
// issued line has been acknowledged.
module grayscale_wr_engine #(
  parameter int ADDR_WIDTH = 42,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_lines,
  input  logic [511:0]          fifo_deq_data,
  input  logic                  fifo_not_empty,
  output logic                  fifo_deq_en,
  input  logic                  wr_almost_full,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [511:0]          wr_req_data,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  lines_sent,
  output logic [LEN_WIDTH-1:0]  lines_acked,
  output logic                  rsp_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  num_q;
  logic                  accept;
  logic                  fire;
  logic                  ack_ok;
  logic                  last_fire;
  logic                  all_acked;

  // A start only counts when idle; it is silently dropped mid-job.
  assign accept = (state == IDLE) && start;

  // One line moves per cycle while running, data is present, the channel has
  // room and the job still has lines left to send.
  assign fire = (state == RUN) && fifo_not_empty && !wr_almost_full &&
                (lines_sent < num_q);

  assign fifo_deq_en = fire;
  assign busy        = (state != IDLE);

  // lines_sent already includes the request currently on wr_req_valid, so a
  // response in the same cycle as its request is legal.
  assign ack_ok = wr_rsp_valid && (lines_acked < lines_sent);

  assign last_fire = fire && (LEN_WIDTH'(lines_sent + 1'b1) == num_q);

  // The job completes on the cycle the final acknowledgement lands, not one
  // cycle after it.
  assign all_acked = (lines_acked == num_q) ||
                     (ack_ok && (LEN_WIDTH'(lines_acked + 1'b1) == num_q));

  // Next-state decode for the IDLE / RUN / DRAIN sequencer.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_lines == '0) ? IDLE : RUN;
      RUN:     if (last_fire) state_nxt = DRAIN;
      DRAIN:   if (all_acked) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job control: state, latched job parameters, progress counters, flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      lines_sent  <= '0;
      lines_acked <= '0;
      done        <= 1'b0;
      rsp_error   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      state <= state_nxt;
      if (accept) begin
        base_q      <= base_addr;
        num_q       <= num_lines;
        lines_sent  <= '0;
        lines_acked <= '0;
        done        <= (num_lines == '0);
        // The new job has nothing outstanding, so a response now is spurious.
        rsp_error   <= wr_rsp_valid;
      end else begin
        if (fire) lines_sent <= lines_sent + 1'b1;
        if (wr_rsp_valid) begin
          if (ack_ok) lines_acked <= lines_acked + 1'b1;
          else        rsp_error   <= 1'b1;
        end
        if ((state == DRAIN) && all_acked) done <= 1'b1;
      end
    end
  end

  // Write request register: one-cycle latency from FIFO pop to request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the wide data register is reset too, so the port reads zero
      // out of reset rather than stale X.
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
    end else begin
      wr_req_valid <= fire;
      if (fire) begin
        wr_req_addr <= base_q + ADDR_WIDTH'(lines_sent);
        wr_req_data <= fifo_deq_data;
      end
    end
  end

endmodule
